// File: rtl/vector_cache_pkg.sv
// Shared vector-cache types for the write-response path: command opcodes,
// transaction id layout, request and write-response payloads, and defaults.
package vector_cache_pkg;

  localparam int unsigned VEC_CACHE_DIR_ID_W         = 4;
  localparam int unsigned VEC_CACHE_SEQ_W            = 8;
  localparam int unsigned VEC_CACHE_SIDEBAND_W       = 8;
  localparam int unsigned VEC_CACHE_WRESP_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    VEC_CACHE_CMD_READ  = 2'd0,
    VEC_CACHE_CMD_WRITE = 2'd1,
    VEC_CACHE_CMD_FLUSH = 2'd2,
    VEC_CACHE_CMD_INVAL = 2'd3
  } vec_cache_cmd_e;

  typedef struct packed {
    logic [VEC_CACHE_DIR_ID_W-1:0] direction_id;
    logic [VEC_CACHE_SEQ_W-1:0]    seq_id;
  } txnid_t;

  typedef struct packed {
    txnid_t                          txnid;
    logic [VEC_CACHE_SIDEBAND_W-1:0] sideband;
  } wr_resp_pld_t;

  typedef struct packed {
    vec_cache_cmd_e                  cmd_opcode;
    txnid_t                          cmd_txnid;
    logic [VEC_CACHE_SIDEBAND_W-1:0] cmd_sideband;
  } input_req_pld_t;

  // True when the command expects a write response.
  function automatic logic is_wr_cmd(input input_req_pld_t p);
    return p.cmd_opcode == VEC_CACHE_CMD_WRITE;
  endfunction

endpackage

// File: rtl/vec_cache_wr_resp_fifo.sv
// Single-clock FIFO of write responses. Occupancy is tracked by an explicit
// counter; full/empty derive from it so the wrapping pointers need no extra bit.
module vec_cache_wr_resp_fifo
  import vector_cache_pkg::*;
#(
  parameter int unsigned DEPTH = VEC_CACHE_WRESP_FIFO_DEPTH,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wr_resp_pld_t     push_data,
  input  logic             pop,
  output wr_resp_pld_t     pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  wr_resp_pld_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     do_push, do_pop;

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign cnt      = cnt_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Next-state: guarded push/pop, pointer advance, occupancy update.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; storage is cleared too so the head reads zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/vec_cache_wr_resp_router.sv
// Write-response router: decodes the direction of each accepted write command
// and queues its response in that direction's FIFO. Non-writes and writes to a
// nonexistent direction are consumed without a response; the latter raise a
// sticky error flag.
module vec_cache_wr_resp_router
  import vector_cache_pkg::*;
#(
  parameter int unsigned NUM_DIR    = 4,
  parameter int unsigned FIFO_DEPTH = VEC_CACHE_WRESP_FIFO_DEPTH,
  parameter int unsigned DIR_W      = $clog2(NUM_DIR),
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_vld,
  output logic                            req_rdy,
  input  input_req_pld_t                  req_pld,
  output logic [NUM_DIR-1:0]              v_wresp_vld,
  input  logic [NUM_DIR-1:0]              v_wresp_rdy,
  output wr_resp_pld_t [NUM_DIR-1:0]      v_wresp_pld,
  output logic [NUM_DIR-1:0][CNT_W-1:0]   v_wresp_cnt,
  output logic                            err_bad_dir
);

  localparam int unsigned CMP_W = VEC_CACHE_DIR_ID_W + 1;

  logic               is_wr;
  logic               dir_ok;
  logic [NUM_DIR-1:0] fifo_full;
  logic [NUM_DIR-1:0] fifo_empty;
  logic [NUM_DIR-1:0] fifo_push;
  logic [NUM_DIR-1:0] fifo_pop;
  logic               err_bad_dir_q, err_bad_dir_d;
  wr_resp_pld_t       push_data;

  assign is_wr     = is_wr_cmd(req_pld);
  assign dir_ok    = {1'b0, req_pld.cmd_txnid.direction_id} < CMP_W'(NUM_DIR);
  assign push_data = '{txnid: req_pld.cmd_txnid, sideband: req_pld.cmd_sideband};

  // Ready/push decode. Matching per direction index keeps out-of-range ids from
  // ever indexing the FIFO vectors; such commands fall through to ready=1.
  always_comb begin
    req_rdy   = 1'b1;
    fifo_push = '0;
    for (int unsigned i = 0; i < NUM_DIR; i++) begin
      if (is_wr && dir_ok &&
          req_pld.cmd_txnid.direction_id[DIR_W-1:0] == DIR_W'(i)) begin
        req_rdy      = !fifo_full[i];
        fifo_push[i] = req_vld && !fifo_full[i];
      end
    end
  end

  // Sticky flag for writes addressed to a nonexistent direction.
  always_comb begin
    err_bad_dir_d = err_bad_dir_q | (req_vld && is_wr && !dir_ok);
  end

  // Error flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_bad_dir_q <= 1'b0;
    else     err_bad_dir_q <= err_bad_dir_d;
  end

  assign err_bad_dir = err_bad_dir_q;
  assign v_wresp_vld = ~fifo_empty;
  assign fifo_pop    = v_wresp_vld & v_wresp_rdy;

  for (genvar g = 0; g < NUM_DIR; g++) begin : g_dir
    vec_cache_wr_resp_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push[g]),
      .push_data (push_data),
      .pop       (fifo_pop[g]),
      .pop_data  (v_wresp_pld[g]),
      .full      (fifo_full[g]),
      .empty     (fifo_empty[g]),
      .cnt       (v_wresp_cnt[g])
    );
  end

endmodule

// File: doc/vec_cache_wr_resp_router.md
Name: vec_cache_wr_resp_router

Overview:
Next-generation write-response path for the vector cache. Decodes the direction from each accepted command's txnid and, for write commands only, enqueues a write response into a per-direction FIFO. Each direction output uses a valid/ready handshake toward its master port. Adds backpressure, buffering, per-direction occupancy reporting and illegal-direction detection.

Parameters:
NUM_DIR, 4, number of response directions (ports); 2..16
FIFO_DEPTH, 4, entries per direction FIFO; power of two, >=2
DIR_W, $clog2(NUM_DIR), derived width used to compare txnid.direction_id
CNT_W, $clog2(FIFO_DEPTH+1), derived occupancy counter width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
req_vld  in  1  command valid
req_rdy  out  1  command accepted when req_vld&&req_rdy
req_pld  in  input_req_pld_t  command payload (cmd_opcode, cmd_txnid, cmd_sideband)
v_wresp_vld  out  NUM_DIR  per-direction response valid
v_wresp_rdy  in  NUM_DIR  per-direction response ready
v_wresp_pld  out  wr_resp_pld_t [NUM_DIR]  per-direction response payload (txnid, sideband)
v_wresp_cnt  out  CNT_W [NUM_DIR]  per-direction FIFO occupancy
err_bad_dir  out  1  sticky: write accepted with direction_id >= NUM_DIR

Behaviour:
- Reset (async assert, sync release): all FIFOs empty, pointers 0, v_wresp_vld=0, v_wresp_cnt=0, err_bad_dir=0, v_wresp_pld=0.
- Command classification: is_wr = (req_pld.cmd_opcode == VEC_CACHE_CMD_WRITE); dir = req_pld.cmd_txnid.direction_id.
- req_rdy (combinational from registered state only, no path from v_wresp_rdy):
  - is_wr && dir<NUM_DIR: req_rdy = !full[dir].
  - Non-write, or dir out of range: req_rdy = 1. The command is consumed with no response.
- Push: on handshake with is_wr && dir<NUM_DIR, write {txnid=cmd_txnid, sideband=cmd_sideband} to FIFO[dir].
- Bad direction: on handshake with is_wr && dir>=NUM_DIR, set err_bad_dir. It clears only on reset. No FIFO is written.
- Latency: a push in cycle N makes the entry visible at v_wresp_vld[dir]/v_wresp_pld[dir] in cycle N+1. There is no same-cycle bypass.
- Pop: v_wresp_vld[i]=!empty[i]. v_wresp_pld[i] = head entry, stable while vld&&!rdy. The head advances on vld&&rdy.
- Ordering: in-order per direction. No ordering across directions.
- Full: req_rdy=0 for writes to that direction, even if the same-cycle pop would free a slot. Other directions are unaffected; only one command is offered per cycle, so a blocked write stalls the input.
- Simultaneous push+pop on the same non-full, non-empty FIFO: count unchanged, both pointers advance.
- Empty FIFO: a push makes count=1. Pop is impossible since vld=0.
- Pointer wrap: pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. full/empty derive from the count.
- v_wresp_cnt[i] is the registered count, 0..FIFO_DEPTH.
- Reset mid-operation: all queued responses are discarded, outputs return to reset values immediately (async).
- X-safety: req_pld is ignored when req_vld=0.

Decomposition:
- vector_cache_pkg: wr_resp_pld_t (existing), input_req_pld_t (existing), VEC_CACHE_CMD_WRITE (existing). Add localparam VEC_CACHE_WRESP_FIFO_DEPTH = 4 as the project default.
- Sub-module vec_cache_wr_resp_fifo: single-clock sync FIFO of wr_resp_pld_t with push/pop/full/empty/cnt, async active-high rst. Instantiated NUM_DIR times via generate.
- The top level holds decode, req_rdy mux and error flag.

Test Plan:
- Reset, then write with txnid.direction_id=2, v_wresp_rdy=4'b1111 -> v_wresp_vld=4'b0100 exactly one cycle after the handshake for one cycle; pld.txnid/sideband match; cnt[2] goes 1 then 0.
- Read opcode to direction 1 -> req_rdy=1, accepted; v_wresp_vld stays 0; all cnt stay 0.
- v_wresp_rdy[0]=0, 5 writes to dir 0 (FIFO_DEPTH=4) -> 4 accepted, cnt[0]=4; 5th sees req_rdy=0. Raising rdy[0] pops one; the 5th is accepted the following cycle. Outputs are in order: txnid A,B,C,D,E.
- Interleaved writes to dirs 0,1,2,3, with rdy[3] held low -> dirs 0..2 drain; dir 3 holds vld=1 with a stable pld until rdy[3]=1.
- NUM_DIR=3, write with direction_id=3 -> req_rdy=1, no vld asserted, err_bad_dir=1 next cycle and stays 1 through subsequent traffic until rst.
- 3 entries queued in dir 1, assert rst for one cycle mid-stream -> v_wresp_vld=0 and cnt=0 immediately; after release a new write to dir 1 returns only the new txnid.
